imem_boot_loader: RTL and testbench

- Serial boot loader that fills the pipeline CPU's writable instruction memory from a byte stream, e.g. from the UART receiver.
- Sequences the instruction-memory write port and holds the CPU stalled (cpu_hold) while a program image is loaded.
- The memory is word-indexed by byte address bits [ADDR_WIDTH+1:2].
- Image format: 16-bit big-endian word count, then count x 32-bit instructions, each MSB byte first (MIPS big-endian).

---
 rtl/imem_boot_loader_if.sv | 28 ++
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the UART receiver and memory; the slave side is the loader.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a big-endian program image (16-bit word count, then 32-bit words)
// from a byte stream into instruction memory while holding the CPU stalled.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_boot_loader_if.slave     bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  state_t                state_reg,        state_next;
  logic [15:0]           count_reg,        count_next;
  logic [1:0]            byte_cnt_reg,     byte_cnt_next;
  logic [31:0]           word_reg,         word_next;
  logic [ADDR_WIDTH:0]   words_loaded_reg, words_loaded_next;
  logic [31:0]           addr_reg,         addr_next;
  logic [31:0]           wdata_reg,        wdata_next;

  logic                  rx_ready_comb;
  logic                  xfer;
  logic [15:0]           hdr_count;
  logic [31:0]           word_shifted;
  logic [15:0]           words_after_write;
  logic [31:0]           word_byte_addr;

  assign xfer         = bus.rx_valid && rx_ready_comb;
  assign hdr_count    = {count_reg[15:8], bus.rx_data};
  assign word_shifted = {word_reg[23:0], bus.rx_data};
  assign words_after_write = {{(15 - ADDR_WIDTH){1'b0}}, words_loaded_reg} + 16'd1;
  assign word_byte_addr    = {{(29 - ADDR_WIDTH){1'b0}}, words_loaded_reg, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      byte_cnt_reg     <= '0;
      word_reg         <= '0;
      words_loaded_reg <= '0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      byte_cnt_reg     <= byte_cnt_next;
      word_reg         <= word_next;
      words_loaded_reg <= words_loaded_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    byte_cnt_next     = byte_cnt_reg;
    word_next         = word_reg;
    words_loaded_next = words_loaded_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    rx_ready_comb     = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next        = HDR_HI;
          words_loaded_next = '0;
          byte_cnt_next     = '0;
        end
      end

      HDR_HI: begin
        rx_ready_comb = 1'b1;
        if (xfer) begin
          count_next[15:8] = bus.rx_data;
          state_next       = HDR_LO;
        end
      end

      HDR_LO: begin
        rx_ready_comb = 1'b1;
        if (xfer) begin
          count_next    = hdr_count;
          byte_cnt_next = '0;
          if (hdr_count == 16'd0) begin
            state_next = DONE;
          end else if ({1'b0, hdr_count} > MAX_COUNT) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        rx_ready_comb = 1'b1;
        if (xfer) begin
          word_next     = word_shifted;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          // Latch the write beat here so addr/wdata are stable for the whole WRITE cycle.
          if (byte_cnt_reg == 2'd3) begin
            state_next = WRITE;
            addr_next  = word_byte_addr;
            wdata_next = word_shifted;
          end
        end
      end

      WRITE: begin
        words_loaded_next = words_loaded_reg + 1'b1;
        byte_cnt_next     = '0;
        if (words_after_write == count_reg) begin
          state_next = DONE;
        end else begin
          state_next = DATA;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_ready   = rx_ready_comb;
  assign bus.imem_we    = (state_reg == WRITE);
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;

  // The CPU only runs when no load is in progress or pending after an error.
  assign cpu_hold     = (state_reg != IDLE) && (state_reg != DONE);
  assign done         = (state_reg == DONE);
  assign err          = (state_reg == ERR);
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as images
// are driven, observed writes are captured by a monitor and compared per test.
module tb_imem_boot_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_boot_loader_if bus();

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int we_long = 0;
  bit we_prev = 1'b0;
  bit toggle_phase = 1'b0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (we_prev) we_long++;
    end
    we_prev = (bus.imem_we === 1'b1);
  end

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp, output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bp && toggle_phase) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        toggle_phase = 1'b0;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        toggle_phase = 1'b1;
        rdy = bus.rx_ready;
        @(posedge clk);
        if (rdy) ok = 1'b1;
      end
    end
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img[$], input bit bp);
    bit ok;
    foreach (img[k]) begin
      send_byte(img[k], bp, ok);
      if (!ok) begin
        compared++;
        mismatched++;
        $display("FAIL byte_accept_timeout idx=%0d byte=%02h not accepted within budget", k, img[k]);
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    compared++;
    if ({bus.rx_ready, bus.imem_we, cpu_hold, done, err} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_flags got=%05b want=00000", {bus.rx_ready, bus.imem_we, cpu_hold, done, err});
    end
    compared++;
    if ({bus.imem_addr, bus.imem_wdata, words_loaded} !== '0) begin
      mismatched++;
      $display("FAIL reset_values addr=%08h wdata=%08h words=%0d want all 0", bus.imem_addr, bus.imem_wdata, words_loaded);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic(input bit bp, input string name);
    logic [7:0] img[$];
    logic [63:0] e, o;
    img = '{8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03};
    obs_q.delete();
    we_long = 0;
    start_load();
    compared++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_start_hold cpu_hold=%b done=%b want 1/0", name, cpu_hold, done);
    end
    exp_q.push_back({32'h0000_0000, 32'h2004_0003});
    exp_q.push_back({32'h0000_0004, 32'h0C00_0003});
    send_image(img, bp);
    repeat (3) @(negedge clk);
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_write_count got=%0d want=%0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL %s_write got=%08h@%08h want=%08h@%08h", name, o[31:0], o[63:32], e[31:0], e[63:32]);
      end
      $display("%s write %08h @ %08h", name, o[31:0], o[63:32]);
    end
    exp_q.delete();
    compared++;
    if ({done, cpu_hold, err} !== 3'b100 || words_loaded !== 9'd2) begin
      mismatched++;
      $display("FAIL %s_final done/hold/err=%03b words=%0d want 100/2", name, {done, cpu_hold, err}, words_loaded);
    end
    compared++;
    if (we_long != 0) begin
      mismatched++;
      $display("FAIL %s_we_width multi-cycle imem_we count=%0d want 0", name, we_long);
    end
  endtask

  task automatic test_zero_count();
    bit ok;
    obs_q.delete();
    start_load();
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    compared++;
    if (!ok || done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 9'd0) begin
      mismatched++;
      $display("FAIL zero_count ok=%b done=%b hold=%b words=%0d want 1/1/0/0", ok, done, cpu_hold, words_loaded);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL zero_count_writes got=%0d want=0", obs_q.size());
    end
    $display("test_zero_count done=%b words=%0d", done, words_loaded);
  endtask

  task automatic test_header_error();
    bit ok;
    obs_q.delete();
    start_load();
    send_byte(8'h01, 1'b0, ok);
    send_byte(8'h01, 1'b0, ok);
    compared++;
    if (!ok || {err, cpu_hold, bus.rx_ready, done} !== 4'b1100) begin
      mismatched++;
      $display("FAIL hdr_err err/hold/ready/done=%04b want 1100", {err, cpu_hold, bus.rx_ready, done});
    end
    repeat (3) @(negedge clk);
    compared++;
    if (obs_q.size() != 0 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL hdr_err_sticky writes=%0d err=%b want 0/1", obs_q.size(), err);
    end
    start_load();
    compared++;
    if ({err, bus.rx_ready, cpu_hold} !== 3'b011) begin
      mismatched++;
      $display("FAIL hdr_err_restart err/ready/hold=%03b want 011", {err, bus.rx_ready, cpu_hold});
    end
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL hdr_err_recover done=%b want 1", done);
    end
    $display("test_header_error err path and restart checked");
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] img[$];
    img = '{8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03};
    obs_q.delete();
    start_load();
    send_image(img, 1'b0);
    compared++;
    if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h2004_0003) begin
      mismatched++;
      $display("FAIL mid_we we=%b wdata=%08h want 1/20040003", bus.imem_we, bus.imem_wdata);
    end
    reset = 1'b0;
    #1;
    compared++;
    if ({bus.rx_ready, bus.imem_we, cpu_hold, done, err} !== 5'b0 ||
        bus.imem_addr !== 32'h0 || bus.imem_wdata !== 32'h0 || words_loaded !== '0) begin
      mismatched++;
      $display("FAIL mid_reset flags=%05b addr=%08h wdata=%08h words=%0d want 0",
               {bus.rx_ready, bus.imem_we, cpu_hold, done, err}, bus.imem_addr, bus.imem_wdata, words_loaded);
    end
    @(negedge clk);
    reset = 1'b1;
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL mid_reset_writes got=%0d want=0", obs_q.size());
    end
    $display("test_reset_mid_load reset applied, rerunning image");
    test_basic(1'b0, "rerun");
  endtask

  task automatic test_full_image();
    logic [7:0] img[$];
    logic [63:0] e, o;
    int n_ok;
    obs_q.delete();
    we_long = 0;
    img.push_back(8'h01);
    img.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      img.push_back(8'(i >> 24));
      img.push_back(8'(i >> 16));
      img.push_back(8'(i >> 8));
      img.push_back(8'(i));
      exp_q.push_back({32'(i * 4), 32'(i)});
    end
    start_load();
    send_image(img, 1'b0);
    repeat (3) @(negedge clk);
    compared++;
    if (obs_q.size() != 256) begin
      mismatched++;
      $display("FAIL full_write_count got=%0d want=256", obs_q.size());
    end
    n_ok = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL full_write got=%08h@%08h want=%08h@%08h", o[31:0], o[63:32], e[31:0], e[63:32]);
      end else begin
        n_ok++;
      end
    end
    exp_q.delete();
    compared++;
    if (bus.imem_addr !== 32'h0000_03FC || bus.imem_wdata !== 32'h0000_00FF) begin
      mismatched++;
      $display("FAIL full_last addr=%08h wdata=%08h want 000003fc/000000ff", bus.imem_addr, bus.imem_wdata);
    end
    compared++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 9'd256 || we_long != 0) begin
      mismatched++;
      $display("FAIL full_final done=%b hold=%b words=%0d we_long=%0d want 1/0/256/0", done, cpu_hold, words_loaded, we_long);
    end
    $display("test_full_image %0d writes matched, words_loaded=%0d", n_ok, words_loaded);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic(1'b0, "basic");
    test_zero_count();
    test_header_error();
    toggle_phase = 1'b0;
    test_basic(1'b1, "backpressure");
    test_reset_mid_load();
    test_full_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
